// File: rtl/inst_bus_router_pkg.sv
// Shared definitions for the instruction bus router.
// Holds the response-id encoding (slave index or ERR), the address-prefix
// constants of the default memory map and the default decode tables.
package inst_bus_router_pkg;

  localparam int unsigned MAX_SLAVES = 8;

  // Slave indices 0..7 fit in the low bits; ERR sits just above them.
  typedef logic [3:0] rsp_id_t;
  localparam rsp_id_t RSP_ERR = 4'd8;

  localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hF000_0000;
  localparam logic [31:0] BOOT_BASE = 32'hBFC0_0000;
  localparam logic [31:0] BOOT_MASK = 32'hFFF0_0000;

  // Slave 0 = ram, slave 1 = bootrom.
  localparam logic [1:0][31:0] DEF_SLV_BASE = {BOOT_BASE, RAM_BASE};
  localparam logic [1:0][31:0] DEF_SLV_MASK = {BOOT_MASK, RAM_MASK};

endpackage

// File: rtl/inst_bus_router_if.sv
// Bundle of the CPU fetch port and the per-slave instruction ports.
// Modports:
//   slave  - router view (accepts CPU fetches, issues slave requests)
//   master - environment view (CPU plus instruction slaves)
interface inst_bus_router_if #(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  logic                                     cpu_req;
  logic [ADDR_W-1:0]                        cpu_addr;
  logic                                     cpu_ready;
  logic                                     cpu_flush;
  logic                                     cpu_rvalid;
  logic [2*DATA_W-1:0]                      cpu_rdata;
  logic                                     cpu_rerr;
  logic [NUM_SLAVES-1:0]                    slv_req;
  logic [ADDR_W-1:0]                        slv_addr;
  logic [NUM_SLAVES-1:0]                    slv_ready;
  logic [NUM_SLAVES-1:0]                    slv_rvalid;
  logic [NUM_SLAVES-1:0][2*DATA_W-1:0]      slv_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_flush, slv_ready, slv_rvalid, slv_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_rerr, slv_req, slv_addr
  );

  modport master (
    output cpu_req, cpu_addr, cpu_flush, slv_ready, slv_rvalid, slv_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_rerr, slv_req, slv_addr
  );
endinterface

// File: rtl/inst_route_fifo.sv
// Response-routing FIFO: records which slave (or ERR) owes each outstanding
// response, plus a discard bit that mark_all sets on every entry at once.
// Ports: clk, rst_n, push/push_id, pop, mark_all in; head_id, head_discard,
// tail_id (youngest entry), count, empty, full out.
module inst_route_fifo
  import inst_bus_router_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  rsp_id_t                    push_id,
  input  logic                       pop,
  input  logic                       mark_all,
  output rsp_id_t                    head_id,
  output logic                       head_discard,
  output rsp_id_t                    tail_id,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  rsp_id_t [DEPTH-1:0] id_mem;
  logic    [DEPTH-1:0] discard;
  logic    [PW-1:0]    wr_ptr;
  logic    [PW-1:0]    rd_ptr;

  assign head_id      = id_mem[rd_ptr];
  assign head_discard = discard[rd_ptr];
  assign tail_id      = id_mem[wr_ptr - 1'b1];
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem  <= '0;
      discard <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= push_id;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Marking free slots is harmless: a push always clears its own slot.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) discard[i] <= 1'b0;
        else if (mark_all)              discard[i] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/inst_bus_router.sv
// Instruction fetch router: decodes CPU fetches onto one of NUM_SLAVES
// instruction slaves, returns in-order responses, answers unmapped fetches
// with an error response, and drops responses owed before a flush.
// Ports: clk, rst_n (async, active-low), bus (slave modport of
// inst_bus_router_if carrying the cpu_* and slv_* signals).
module inst_bus_router
  import inst_bus_router_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_bus_router_if.slave  bus
);
  logic [NUM_SLAVES-1:0]  hit_vec;
  logic                   mapped;
  rsp_id_t                hit_id;
  logic [ADDR_W-1:0]      sel_mask;
  logic                   block;
  logic                   push;
  logic                   pop;
  rsp_id_t                head_id;
  rsp_id_t                tail_id;
  logic                   head_discard;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic [NUM_SLAVES-1:0]  head_vec;
  logic                   head_is_err;
  logic                   head_rvalid;
  logic [2*DATA_W-1:0]    head_rdata;
  logic                   deliver;
  logic                   proto_err;

  // Lowest-index hit wins.
  always_comb begin
    hit_vec  = '0;
    mapped   = 1'b0;
    hit_id   = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!mapped && ((bus.cpu_addr & SLV_MASK[i]) == SLV_BASE[i])) begin
        mapped     = 1'b1;
        hit_vec[i] = 1'b1;
        hit_id     = rsp_id_t'(i);
        sel_mask   = SLV_MASK[i];
      end
    end
  end

  // Responses from different slaves could overtake each other, so a switch
  // of target waits for the FIFO to drain.
  assign block = mapped && !empty && (tail_id != hit_id);

  always_comb begin
    bus.cpu_ready = rst_n && !full && !bus.cpu_flush &&
                    (!mapped || ((|(hit_vec & bus.slv_ready)) && !block));
    bus.slv_req   = (rst_n && bus.cpu_req && !bus.cpu_flush && !full && !block)
                    ? hit_vec : '0;
    bus.slv_addr  = (bus.cpu_addr & ~sel_mask) >> 2;
  end

  assign push = bus.cpu_req && bus.cpu_ready;

  inst_route_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_id      (mapped ? hit_id : RSP_ERR),
    .pop          (pop),
    .mark_all     (bus.cpu_flush),
    .head_id      (head_id),
    .head_discard (head_discard),
    .tail_id      (tail_id),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  always_comb begin
    head_vec   = '0;
    head_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (head_id == rsp_id_t'(i)) begin
        head_vec[i] = 1'b1;
        head_rdata  = bus.slv_rdata[i];
      end
    end
  end

  assign head_is_err = (head_id == RSP_ERR);
  assign head_rvalid = |(head_vec & bus.slv_rvalid);
  assign pop         = !empty && (head_is_err || head_rvalid);
  // A pop coinciding with a flush still retires the entry but stays silent.
  assign deliver     = pop && !head_discard && !bus.cpu_flush;

  always_comb begin
    bus.cpu_rvalid = deliver;
    bus.cpu_rerr   = deliver && head_is_err;
    bus.cpu_rdata  = (deliver && !head_is_err) ? head_rdata : '0;
  end

  // Any response not owed by the head slave is dropped and remembered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          proto_err <= 1'b0;
    else if (|(bus.slv_rvalid & ~(empty ? '0 : head_vec))) proto_err <= 1'b1;
  end

`ifndef SYNTHESIS
  a_proto_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    proto_err |=> proto_err);
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= ($clog2(DEPTH)+1)'(DEPTH));
`endif
endmodule

// File: tb/tb_inst_bus_router.sv
module tb_inst_bus_router;
  import inst_bus_router_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] DB = 64'hB00B_B00B_CAFE_F00D;

  always #5 clk = ~clk;

  inst_bus_router_if #(.NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus ();

  inst_bus_router #(
    .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Advance to 1 ns after the next rising edge; inputs change here and
  // outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_flush = 1'b0;
    bus.slv_ready = 2'b11; bus.slv_rvalid = '0; bus.slv_rdata = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0000;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.cpu_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.cpu_ready); else passes++;
    checks++; if (bus.slv_req !== 2'b00) $display("FAIL reset_slv_req: got %b want 00", bus.slv_req); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.cpu_rvalid); else passes++;
    checks++; if (bus.cpu_rerr !== 1'b0) $display("FAIL reset_rerr: got %b want 0", bus.cpu_rerr); else passes++;
    checks++; if (bus.cpu_rdata !== 64'd0) $display("FAIL reset_rdata: got %h want 0", bus.cpu_rdata); else passes++;
    cyc(); cyc();
    idle(); rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0000; #1;
    checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", bus.cpu_ready); else passes++;
    checks++; if (bus.slv_req !== 2'b01) $display("FAIL b2b_req0: got %b want 01", bus.slv_req); else passes++;
    checks++; if (bus.slv_addr !== 32'h0) $display("FAIL b2b_addr0: got %h want 0", bus.slv_addr); else passes++;
    cyc();
    bus.cpu_addr = 32'h8000_0008; bus.slv_rvalid = 2'b01; bus.slv_rdata[0] = D0; #1;
    checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", bus.cpu_ready); else passes++;
    checks++; if (bus.slv_addr !== 32'h2) $display("FAIL b2b_addr1: got %h want 2", bus.slv_addr); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== D0) $display("FAIL b2b_rsp0: got v=%b d=%h want v=1 d=%h", bus.cpu_rvalid, bus.cpu_rdata, D0); else passes++;
    cyc();
    bus.cpu_req = 1'b0; bus.slv_rdata[0] = D1; #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== D1 || bus.cpu_rerr !== 1'b0) $display("FAIL b2b_rsp1: got v=%b d=%h e=%b want v=1 d=%h e=0", bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_rerr, D1); else passes++;
    cyc();
    bus.slv_rvalid = 2'b00; #1;
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 64'd0) $display("FAIL b2b_idle: got v=%b d=%h want v=0 d=0", bus.cpu_rvalid, bus.cpu_rdata); else passes++;
    idle(); cyc();
  endtask

  task automatic test_unmapped();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h1000_0000; bus.slv_ready = 2'b00; #1;
    checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL unm_ready: got %b want 1", bus.cpu_ready); else passes++;
    checks++; if (bus.slv_req !== 2'b00) $display("FAIL unm_slv_req: got %b want 00", bus.slv_req); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL unm_early: got %b want 0", bus.cpu_rvalid); else passes++;
    cyc();
    bus.cpu_req = 1'b0; #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rerr !== 1'b1 || bus.cpu_rdata !== 64'd0) $display("FAIL unm_rsp: got v=%b e=%b d=%h want v=1 e=1 d=0", bus.cpu_rvalid, bus.cpu_rerr, bus.cpu_rdata); else passes++;
    checks++; if (bus.slv_req !== 2'b00) $display("FAIL unm_slv_req2: got %b want 00", bus.slv_req); else passes++;
    cyc(); #1;
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rerr !== 1'b0) $display("FAIL unm_after: got v=%b e=%b want 0 0", bus.cpu_rvalid, bus.cpu_rerr); else passes++;
    idle(); cyc();
  endtask

  task automatic test_ordering();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0000; #1;
    checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL ord_ram_ready: got %b want 1", bus.cpu_ready); else passes++;
    cyc();
    bus.cpu_addr = 32'hBFC0_0000; #1;
    checks++; if (bus.cpu_ready !== 1'b0 || bus.slv_req !== 2'b00) $display("FAIL ord_block: got r=%b s=%b want r=0 s=00", bus.cpu_ready, bus.slv_req); else passes++;
    cyc();
    bus.slv_rvalid = 2'b01; bus.slv_rdata[0] = D0; #1;
    checks++; if (bus.cpu_ready !== 1'b0) $display("FAIL ord_block_pop: got %b want 0", bus.cpu_ready); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== D0) $display("FAIL ord_ram_rsp: got v=%b d=%h want v=1 d=%h", bus.cpu_rvalid, bus.cpu_rdata, D0); else passes++;
    cyc();
    bus.slv_rvalid = 2'b00; #1;
    checks++; if (bus.cpu_ready !== 1'b1 || bus.slv_req !== 2'b10) $display("FAIL ord_boot_issue: got r=%b s=%b want r=1 s=10", bus.cpu_ready, bus.slv_req); else passes++;
    checks++; if (bus.slv_addr !== 32'h0) $display("FAIL ord_boot_addr: got %h want 0", bus.slv_addr); else passes++;
    cyc();
    bus.cpu_req = 1'b0; bus.slv_rvalid = 2'b10; bus.slv_rdata[1] = DB; #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== DB) $display("FAIL ord_boot_rsp: got v=%b d=%h want v=1 d=%h", bus.cpu_rvalid, bus.cpu_rdata, DB); else passes++;
    cyc();
    idle(); cyc();
  endtask

  task automatic test_full();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL full_fill%0d: got %b want 1", i, bus.cpu_ready); else passes++;
      cyc();
    end
    #1;
    checks++; if (bus.cpu_ready !== 1'b0 || bus.slv_req !== 2'b00) $display("FAIL full_stall: got r=%b s=%b want r=0 s=00", bus.cpu_ready, bus.slv_req); else passes++;
    cyc();
    bus.slv_rvalid = 2'b01; bus.slv_rdata[0] = D1; #1;
    checks++; if (bus.cpu_ready !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", bus.cpu_ready); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b1) $display("FAIL full_pop: got %b want 1", bus.cpu_rvalid); else passes++;
    cyc();
    bus.slv_rvalid = 2'b00; #1;
    checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL full_reopen: got %b want 1", bus.cpu_ready); else passes++;
    cyc();
    bus.cpu_req = 1'b0; bus.slv_rvalid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.cpu_rvalid !== 1'b1) $display("FAIL full_drain%0d: got %b want 1", i, bus.cpu_rvalid); else passes++;
      cyc();
    end
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL full_empty: got %b want 0", bus.cpu_rvalid); else passes++;
    idle(); cyc();
  endtask

  task automatic test_flush();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0010;
    cyc(); cyc(); cyc();
    bus.cpu_flush = 1'b1; bus.slv_rvalid = 2'b01; bus.slv_rdata[0] = D0; #1;
    checks++; if (bus.cpu_ready !== 1'b0 || bus.slv_req !== 2'b00) $display("FAIL flush_hold: got r=%b s=%b want r=0 s=00", bus.cpu_ready, bus.slv_req); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL flush_same_cycle: got %b want 0", bus.cpu_rvalid); else passes++;
    cyc();
    bus.cpu_flush = 1'b0; bus.cpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL flush_drop%0d: got %b want 0", i, bus.cpu_rvalid); else passes++;
      cyc();
    end
    bus.slv_rvalid = 2'b00; bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0020; #1;
    checks++; if (bus.cpu_ready !== 1'b1) $display("FAIL flush_new_ready: got %b want 1", bus.cpu_ready); else passes++;
    checks++; if (bus.slv_addr !== 32'h8) $display("FAIL flush_new_addr: got %h want 8", bus.slv_addr); else passes++;
    cyc();
    bus.cpu_req = 1'b0; bus.slv_rvalid = 2'b01; bus.slv_rdata[0] = D1; #1;
    checks++; if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== D1) $display("FAIL flush_new_rsp: got v=%b d=%h want v=1 d=%h", bus.cpu_rvalid, bus.cpu_rdata, D1); else passes++;
    cyc();
    idle(); cyc();
  endtask

  task automatic test_reset_mid();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h8000_0000;
    cyc(); cyc();
    bus.slv_rvalid = 2'b01; bus.slv_rdata[0] = D0; #1;
    checks++; if (bus.cpu_rvalid !== 1'b1) $display("FAIL rstm_pre: got %b want 1", bus.cpu_rvalid); else passes++;
    rst_n = 1'b0; #1;
    checks++; if (bus.cpu_ready !== 1'b0 || bus.slv_req !== 2'b00) $display("FAIL rstm_req: got r=%b s=%b want r=0 s=00", bus.cpu_ready, bus.slv_req); else passes++;
    checks++; if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 64'd0 || bus.cpu_rerr !== 1'b0) $display("FAIL rstm_rsp: got v=%b d=%h e=%b want 0 0 0", bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_rerr); else passes++;
    cyc();
    bus.cpu_req = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.cpu_rvalid !== 1'b0) $display("FAIL rstm_late%0d: got %b want 0", i, bus.cpu_rvalid); else passes++;
      cyc();
    end
    idle(); cyc();
  endtask

  initial begin
    idle();
    test_reset();
    test_back_to_back();
    test_unmapped();
    test_ordering();
    test_full();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/inst_bus_router.md
INST_BUS_ROUTER -- requirements
Module: inst_bus_router

Interface
REQ-001 Parameter NUM_SLAVES, default 2: number of instruction slaves (ram, bootrom, ...), range 1..8.
REQ-002 Parameter ADDR_W, default 32: CPU byte-address width.
REQ-003 Parameter DATA_W, default 32: instruction word width; each response carries two words.
REQ-004 Parameter DEPTH, default 4: maximum outstanding requests, power of two, at least 2.
REQ-005 Parameters SLV_BASE and SLV_MASK, each NUM_SLAVES x ADDR_W: per-slave decode base and mask.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 cpu_req  input  1  fetch request valid.
REQ-009 cpu_addr  input  ADDR_W  fetch byte address, word aligned.
REQ-010 cpu_ready  output  1  request accepted this cycle when high together with cpu_req.
REQ-011 cpu_flush  input  1  discard all outstanding responses (redirect or exception).
REQ-012 cpu_rvalid  output  1  response valid.
REQ-013 cpu_rdata  output  2*DATA_W  {word at addr+4, word at addr}.
REQ-014 cpu_rerr  output  1  response is an unmapped-address error.
REQ-015 slv_req  output  NUM_SLAVES  one-hot per-slave request.
REQ-016 slv_addr  output  ADDR_W  shared word address, cpu_addr masked with the inverse of SLV_MASK of the selected slave, then shifted right by 2.
REQ-017 slv_ready  input  NUM_SLAVES  per-slave request accept.
REQ-018 slv_rvalid  input  NUM_SLAVES  per-slave in-order response valid.
REQ-019 slv_rdata  input  NUM_SLAVES x 2*DATA_W  per-slave response data.

Function
REQ-020 Decode: slave i hits when (cpu_addr AND SLV_MASK[i]) equals SLV_BASE[i]; the lowest index wins; no hit means unmapped.
REQ-021 A response-routing FIFO of DEPTH entries holds {target id or ERR, discard bit}; count ranges 0..DEPTH.
REQ-022 cpu_ready: high only if count < DEPTH and cpu_flush is low and (unmapped, or slv_ready[hit] is high with no ordering block); no full-bypass on same-cycle pop.
REQ-023 Ordering block: a request to slave k while the FIFO is non-empty and the youngest entry targets a different slave or ERR is held with cpu_ready low until the FIFO is empty.
REQ-024 slv_req[hit] equals cpu_req AND NOT cpu_flush AND count < DEPTH AND no ordering block; it is combinational, and no slv_req is raised for an unmapped address.
REQ-025 Acceptance pushes {hit id or ERR, discard=0}.
REQ-026 Head is a slave h: the entry pops when slv_rvalid[h] is high; cpu_rvalid = slv_rvalid[h] AND NOT discard; cpu_rdata = slv_rdata[h]; cpu_rerr = 0.
REQ-027 Head is ERR: it pops in the first cycle it is head, which is no earlier than the cycle after acceptance; cpu_rvalid = NOT discard; cpu_rerr = 1; cpu_rdata = 0.
REQ-028 cpu_flush sets the discard bit of every entry present in that cycle; a pop in the same cycle still occurs and is suppressed.
REQ-029 Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-030 slv_rvalid from a slave other than the head target is ignored; a sticky internal protocol-error bit is set, visible only in simulation assertions.
REQ-031 When cpu_rvalid is low, cpu_rdata and cpu_rerr are 0.

Reset
REQ-032 rst_n low clears the FIFO pointers, count, discard bits and protocol-error bit immediately.
REQ-033 During reset cpu_ready, cpu_rvalid, cpu_rerr, slv_req and cpu_rdata are 0.
REQ-034 Responses arriving after a reset taken mid-operation are ignored while count is 0.

Structure
REQ-035 The shared package holds the response-id typedef (slave index plus ERR encoding), the address-prefix constants and the default decode tables.
REQ-036 One sub-module, inst_route_fifo, implements the ID FIFO together with its discard-bit mark-all operation.

Verification
REQ-037 Two back-to-back ram fetches at 0x80000000 and 0x80000008 -> two cpu_rvalid pulses in order with matching data and cpu_rerr=0.
REQ-038 A fetch to unmapped 0x10000000 -> cpu_rvalid=1 and cpu_rerr=1 with cpu_rdata=0 in the next cycle, and no slv_req pulse.
REQ-039 A ram fetch outstanding then a bootrom fetch at 0xBFC00000 -> cpu_ready=0 until the ram response pops, then the bootrom request is issued.
REQ-040 DEPTH=4 with 4 accepted ram requests and no response -> cpu_ready=0; one response pops and cpu_ready returns high in the next cycle.
REQ-041 cpu_flush with 3 outstanding -> those 3 responses produce no cpu_rvalid; a new fetch issued after the flush returns normally.
REQ-042 rst_n asserted with 2 requests outstanding -> outputs go to 0 immediately, and late slv_rvalid produces no cpu_rvalid.
